// File: rtl/parametric_demux_bank_pkg.sv
// Shared types and defaults for the parametric demux bank and its decoder.
package parametric_demux_bank_pkg;

    // Bank controller state: accepting writes, or sweeping entries to zero
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } demux_bank_state_t;

    localparam int DEFAULT_MEM_WIDTH = 16;
    localparam int DEFAULT_MEM_DEPTH = 16;

    // Index width for a bank of the given depth (depth is at least 2)
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/parametric_demux_bank_onehot_decoder.sv
// Binary index to one-hot enable decoder with an out-of-range flag.
// N need not be a power of two; indices N..2**AW-1 raise out_of_range
// instead of enabling any output.
module onehot_decoder
    import parametric_demux_bank_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = addr_width(N)
) (
    input  logic [AW-1:0] addr,
    input  logic          en,
    output logic [N-1:0]  we,
    output logic          out_of_range
);

    localparam int          AWP   = AW + 1;
    localparam logic [AW:0] N_EXT = AWP'(N);

    logic in_range;

    // Full-width compare, one bit wider than the index so N itself is representable
    assign in_range     = ({1'b0, addr} < N_EXT);
    assign out_of_range = en && !in_range;

    // One enable per entry, only for a valid in-range index
    always_comb begin
        we = '0;
        for (int i = 0; i < N; i++) begin
            we[i] = en && in_range && (addr == AW'(i));
        end
    end

endmodule

// File: rtl/parametric_demux_bank.sv
// Write-side bank: mem_depth entries of mem_width bits, one write per cycle
// over valid/ready, the whole bank exported as one flat bus for a read mux,
// plus a sequential clear engine that zeroes one entry per cycle.
//
// Handshake: a write transfers on a rising edge where wr_valid and wr_ready
// are both 1 (fire). wr_ready depends only on the controller state (and is
// low while in reset), never on wr_valid. A stalled requester keeps
// wr_addr/wr_data stable until fire. Out-of-range fires still complete and
// only produce a one-cycle wr_err pulse.
module parametric_demux_bank
    import parametric_demux_bank_pkg::*;
#(
    parameter  int mem_width = DEFAULT_MEM_WIDTH,
    parameter  int mem_depth = DEFAULT_MEM_DEPTH,
    localparam int addr_w    = addr_width(mem_depth)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [addr_w-1:0]              wr_addr,
    input  logic [mem_width-1:0]           wr_data,
    output logic                           wr_err,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic [mem_width*mem_depth-1:0] data_out,
    output logic [mem_depth-1:0]           entry_valid,
    output demux_bank_state_t              dbg_state
);

    localparam logic [addr_w-1:0] LAST_IDX = addr_w'(mem_depth - 1);

    demux_bank_state_t     state;
    logic [addr_w-1:0]     clr_idx;
    logic [mem_width-1:0]  mem [mem_depth];
    logic                  fire;
    logic                  sweeping;
    logic                  wr_oor;
    logic [mem_depth-1:0]  wr_we;

    assign sweeping  = (state == S_CLEAR);
    assign clr_busy  = sweeping;
    assign wr_ready  = rst_n && (state == S_IDLE);
    assign fire      = wr_valid && wr_ready;
    assign dbg_state = state;

    onehot_decoder #(
        .N  (mem_depth),
        .AW (addr_w)
    ) u_wr_dec (
        .addr         (wr_addr),
        .en           (fire),
        .we           (wr_we),
        .out_of_range (wr_oor)
    );

    // Controller: idle until a clear request, then sweep every index exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            clr_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_req) begin
                        state   <= S_CLEAR;
                        clr_idx <= '0;
                    end
                end
                S_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state   <= S_IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    clr_idx <= '0;
                end
            endcase
        end
    end

    // Error pulse for the cycle after an accepted out-of-range write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_oor;
        end
    end

    // Storage: the sweep and writes never overlap since writes only fire in S_IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < mem_depth; i++) begin
                mem[i] <= '0;
            end
            entry_valid <= '0;
        end else begin
            for (int i = 0; i < mem_depth; i++) begin
                if (sweeping && (clr_idx == addr_w'(i))) begin
                    mem[i]         <= '0;
                    entry_valid[i] <= 1'b0;
                end else if (wr_we[i]) begin
                    mem[i]         <= wr_data;
                    entry_valid[i] <= 1'b1;
                end
            end
        end
    end

    // Flat bank image, entry i in bits [(i+1)*mem_width-1 : i*mem_width]
    for (genvar g = 0; g < mem_depth; g++) begin : g_flat
        assign data_out[g*mem_width +: mem_width] = mem[g];
    end

endmodule

// File: tb/tb_parametric_demux_bank.sv
// Bench for parametric_demux_bank: a depth-16 instance for the main
// features and a depth-12 instance for out-of-range addresses.
`timescale 1ns/1ps
module tb_parametric_demux_bank;
    import parametric_demux_bank_pkg::*;

    localparam int W   = 16;
    localparam int D   = 16;
    localparam int DS  = 12;
    localparam int AW  = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // depth-16 instance
    logic              wr_valid = 1'b0;
    logic [AW-1:0]     wr_addr  = '0;
    logic [W-1:0]      wr_data  = '0;
    logic              clr_req  = 1'b0;
    logic              wr_ready;
    logic              wr_err;
    logic              clr_busy;
    logic [W*D-1:0]    data_out;
    logic [D-1:0]      entry_valid;
    demux_bank_state_t dbg_state;

    // depth-12 instance
    logic              wr_valid_s = 1'b0;
    logic [AW-1:0]     wr_addr_s  = '0;
    logic [W-1:0]      wr_data_s  = '0;
    logic              clr_req_s  = 1'b0;
    logic              wr_ready_s;
    logic              wr_err_s;
    logic              clr_busy_s;
    logic [W*DS-1:0]   data_out_s;
    logic [DS-1:0]     entry_valid_s;
    demux_bank_state_t dbg_state_s;

    parametric_demux_bank #(.mem_width(W), .mem_depth(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .data_out    (data_out),
        .entry_valid (entry_valid),
        .dbg_state   (dbg_state)
    );

    parametric_demux_bank #(.mem_width(W), .mem_depth(DS)) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid_s),
        .wr_ready    (wr_ready_s),
        .wr_addr     (wr_addr_s),
        .wr_data     (wr_data_s),
        .wr_err      (wr_err_s),
        .clr_req     (clr_req_s),
        .clr_busy    (clr_busy_s),
        .data_out    (data_out_s),
        .entry_valid (entry_valid_s),
        .dbg_state   (dbg_state_s)
    );

    // ---------------- scoreboard ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    int           addr_q[$];
    logic [W-1:0] model_mem[D];
    logic [D-1:0] model_valid;

    function automatic logic [W*D-1:0] model_flat();
        logic [W*D-1:0] f;
        f = '0;
        for (int i = 0; i < D; i++) f[i*W +: W] = model_mem[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        model_valid = '0;
        exp_q.delete();
        addr_q.delete();
    endtask

    // Compare every write that fired on the previous edge (read back like a mux port)
    task automatic sb_drain();
        logic [W-1:0] e;
        int           a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            checks++;
            if (data_out[a*W +: W] !== e || entry_valid[a] !== 1'b1) begin
                failures++;
                $display("FAIL sb_entry%0d: got data=%h valid=%b, expected data=%h valid=1",
                         a, data_out[a*W +: W], entry_valid[a], e);
            end
        end
    endtask

    task automatic check_bank(input string name);
        checks++;
        if (data_out !== model_flat() || entry_valid !== model_valid) begin
            failures++;
            $display("FAIL %s: got data_out=%h valid=%h, expected data_out=%h valid=%h",
                     name, data_out, entry_valid, model_flat(), model_valid);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present one write, wait for wr_ready, let it fire; returns 1ns after the fire edge
    task automatic wr_beat(input int a, input logic [W-1:0] d);
        int n;
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = d;
        n = 0;
        @(negedge clk);
        sb_drain();
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            sb_drain();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout: got wr_ready=0 for 100 cycles, expected 1");
        end
        @(posedge clk);
        model_mem[a]   = d;
        model_valid[a] = 1'b1;
        exp_q.push_back(d);
        addr_q.push_back(a);
        #1;
    endtask

    task automatic wr_idle();
        wr_valid = 1'b0;
        @(negedge clk);
        sb_drain();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (data_out !== '0 || entry_valid !== '0 || wr_ready !== 1'b1 || dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL reset_state: got data_out=%h valid=%h ready=%b, expected 0 0 1",
                     data_out, entry_valid, wr_ready);
        end
        wr_beat(1, 16'hAAAA);
        wr_beat(6, 16'h5555);
        wr_beat(14, 16'hC0DE);
        wr_idle();
        check_bank("pre_reset_bank");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== '0 || entry_valid !== '0 || wr_ready !== 1'b0 ||
            clr_busy !== 1'b0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL in_reset: got data_out=%h valid=%h ready=%b busy=%b err=%b, expected all 0",
                     data_out, entry_valid, wr_ready, clr_busy, wr_err);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: got ready=%b busy=%b, expected 1 0", wr_ready, clr_busy);
        end
    endtask

    task automatic test_writes();
        @(posedge clk); #1;
        wr_beat(3, 16'hBEEF);
        wr_beat(15, 16'h1234);
        wr_idle();
        checks++;
        if (data_out[63:48] !== 16'hBEEF || data_out[255:240] !== 16'h1234 ||
            entry_valid !== 16'h8008) begin
            failures++;
            $display("FAIL b2b_pair: got e3=%h e15=%h valid=%h, expected BEEF 1234 8008",
                     data_out[63:48], data_out[255:240], entry_valid);
        end
        // same address twice in a row: last write wins
        @(posedge clk); #1;
        wr_beat(5, 16'h1111);
        wr_beat(5, 16'h2222);
        wr_idle();
        check_bank("last_write_wins");
        // random back-to-back traffic
        @(posedge clk); #1;
        for (int i = 0; i < 24; i++) begin
            wr_beat($urandom_range(0, D - 1), W'($urandom_range(0, 16'hFFFF)));
        end
        wr_idle();
        check_bank("random_writes");
    endtask

    task automatic test_out_of_range();
        logic [W*DS-1:0] exp_flat;
        exp_flat = '0;
        exp_flat[11*W +: W] = 16'h0B0B;
        @(posedge clk); #1;
        wr_valid_s = 1'b1;
        wr_addr_s  = 4'd11;
        wr_data_s  = 16'h0B0B;
        @(negedge clk);
        checks++;
        if (wr_ready_s !== 1'b1) begin
            failures++;
            $display("FAIL oor_ready: got %b, expected 1", wr_ready_s);
        end
        @(posedge clk); #1;
        wr_addr_s = 4'd12;
        wr_data_s = 16'hDEAD;
        @(negedge clk);
        checks++;
        if (data_out_s !== exp_flat || entry_valid_s !== 12'h800 || wr_err_s !== 1'b0) begin
            failures++;
            $display("FAIL oor_last_entry: got data=%h valid=%h err=%b, expected data=%h valid=800 err=0",
                     data_out_s, entry_valid_s, wr_err_s, exp_flat);
        end
        @(posedge clk); #1;
        wr_addr_s = 4'd13;
        wr_data_s = 16'hBAD1;
        @(negedge clk);
        checks++;
        if (wr_err_s !== 1'b1 || data_out_s !== exp_flat || entry_valid_s !== 12'h800) begin
            failures++;
            $display("FAIL oor_addr12: got err=%b data=%h valid=%h, expected err=1 data unchanged",
                     wr_err_s, data_out_s, entry_valid_s);
        end
        @(posedge clk); #1;
        wr_valid_s = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_err_s !== 1'b1 || data_out_s !== exp_flat || entry_valid_s !== 12'h800) begin
            failures++;
            $display("FAIL oor_addr13: got err=%b data=%h valid=%h, expected err=1 data unchanged",
                     wr_err_s, data_out_s, entry_valid_s);
        end
        @(negedge clk);
        checks++;
        if (wr_err_s !== 1'b0) begin
            failures++;
            $display("FAIL oor_pulse_len: got err=%b, expected 0", wr_err_s);
        end
    endtask

    task automatic test_clear();
        int cnt;
        int guard;
        int ready_seen;
        @(posedge clk); #1;
        for (int i = 0; i < D; i++) wr_beat(i, W'($urandom_range(1, 16'hFFFF)));
        wr_idle();
        check_bank("filled_bank");
        @(posedge clk); #1;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        cnt = 0;
        guard = 0;
        ready_seen = 0;
        while (guard < 100) begin
            @(negedge clk);
            guard++;
            if (!clr_busy) begin
                clr_req = 1'b0;
                break;
            end
            cnt++;
            if (wr_ready !== 1'b0) ready_seen++;
            if (cnt == 5)  clr_req = 1'b1;
            if (cnt == 6)  clr_req = 1'b0;
            if (cnt == 16) clr_req = 1'b1;
        end
        checks++;
        if (cnt !== D) begin
            failures++;
            $display("FAIL clr_busy_len: got %0d cycles, expected %0d", cnt, D);
        end
        checks++;
        if (ready_seen !== 0) begin
            failures++;
            $display("FAIL clr_ready_low: got wr_ready=1 on %0d sweep cycles, expected 0", ready_seen);
        end
        model_reset();
        check_bank("cleared_bank");
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_no_restart: got busy=%b ready=%b, expected 0 1", clr_busy, wr_ready);
        end
    endtask

    task automatic test_collision();
        int stall;
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_addr  = 4'd0;
        wr_data  = 16'hA5A5;
        clr_req  = 1'b1;
        @(posedge clk);
        model_mem[0]   = 16'hA5A5;
        model_valid[0] = 1'b1;
        exp_q.push_back(16'hA5A5);
        addr_q.push_back(0);
        #1;
        clr_req = 1'b0;
        wr_addr = 4'd7;
        wr_data = 16'h7777;
        @(negedge clk);
        sb_drain();
        checks++;
        if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL coll_sweep_start: got busy=%b ready=%b, expected 1 0", clr_busy, wr_ready);
        end
        @(negedge clk);
        checks++;
        if (data_out[15:0] !== 16'h0000 || entry_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL coll_entry0_cleared: got data=%h valid=%b, expected 0000 0",
                     data_out[15:0], entry_valid[0]);
        end
        stall = 0;
        while (stall < 100) begin
            @(negedge clk);
            if (wr_ready) break;
            stall++;
        end
        checks++;
        if (stall !== 14) begin
            failures++;
            $display("FAIL coll_stall_len: got %0d stalled cycles, expected 14", stall);
        end
        model_reset();
        @(posedge clk);
        model_mem[7]   = 16'h7777;
        model_valid[7] = 1'b1;
        exp_q.push_back(16'h7777);
        addr_q.push_back(7);
        #1;
        wr_valid = 1'b0;
        @(negedge clk);
        sb_drain();
        check_bank("coll_held_write");
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) wr_beat(i, W'($urandom_range(1, 16'hFFFF)));
        wr_idle();
        check_bank("pre_sweep_bank");
        @(posedge clk); #1;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        cnt = 0;
        while (cnt < 5) begin
            @(negedge clk);
            if (!clr_busy) break;
            cnt++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt !== 5 || clr_busy !== 1'b0 || dbg_state !== S_IDLE || data_out !== '0 ||
            entry_valid !== '0 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_sweep_reset: got cnt=%0d busy=%b state=%0d data=%h valid=%h ready=%b, expected 5 0 0 0 0 0",
                     cnt, clr_busy, dbg_state, data_out, entry_valid, wr_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b0 || wr_ready !== 1'b1 || dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL post_abort_idle: got busy=%b ready=%b, expected 0 1", clr_busy, wr_ready);
        end
        @(posedge clk); #1;
        wr_beat(9, 16'h0909);
        wr_idle();
        check_bank("post_abort_write");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_writes();
        test_out_of_range();
        test_clear();
        test_collision();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
